// File: rtl/arbitro_pkg.sv
// Shared constants, FSM states and helpers for the round-robin burst arbiter.
package arbitro_pkg;

   localparam int NPORT = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NPORT-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NPORT-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping mod 4.
module arb_rr_pick
   import arbitro_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   logic [NPORT-1:0] rot;
   logic [NPORT-1:0] lsb;
   logic [IDX_W-1:0] off;

   always_comb begin
      for (int k = 0; k < NPORT; k++) begin
         rot[k] = req[ptr + IDX_W'(k)];
      end
   end

   // Isolate the lowest set bit so the decode below is one-hot.
   assign lsb = rot & (~rot + 4'd1);

   always_comb begin
      off = '0;
      unique case (1'b1)
         lsb[0]:  off = 2'd0;
         lsb[1]:  off = 2'd1;
         lsb[2]:  off = 2'd2;
         lsb[3]:  off = 2'd3;
         default: off = 2'd0;
      endcase
   end

   assign gnt_idx = ptr + off;
   assign any     = |req;

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin burst arbiter: four input FIFOs to four output FIFOs,
// one-cycle pop-to-push pipeline and per-input saturating word counters.
module arbitro_rr
   import arbitro_pkg::*;
#(
   parameter int BURST = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       empty,
   input  logic [3:0]       afull,
   input  logic [1:0]       dest,
   output logic [3:0]       pop,
   output logic [3:0]       push,
   output logic [1:0]       mux_sel,
   output logic             idle,
   input  logic [1:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_out
);

   localparam int BC_W = $clog2(BURST + 1);

   state_t           state, state_nx;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
   logic [IDX_W-1:0] cur, cur_nx;
   logic [BC_W-1:0]  bcnt, bcnt_nx;
   logic             vld_d;
   logic [IDX_W-1:0] sel_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             stall;
   logic [CNT_W-1:0] cnt [NPORT];

   assign stall = |afull;

   arb_rr_pick u_pick (
      .req     (~empty),
      .ptr     (rr_ptr),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      state_nx  = state;
      rr_ptr_nx = rr_ptr;
      cur_nx    = cur;
      bcnt_nx   = bcnt;
      pop       = '0;
      unique case (state)
         IDLE: begin
            if (pick_any && !stall) begin
               cur_nx   = pick_idx;
               bcnt_nx  = '0;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            // Backpressure freezes the grant and its burst count.
            if (!stall) begin
               if (!empty[cur]) begin
                  pop     = onehot(cur);
                  bcnt_nx = bcnt + 1'b1;
                  if (bcnt_nx == BC_W'(BURST)) begin
                     state_nx  = IDLE;
                     rr_ptr_nx = cur + 1'b1;
                  end
               end else begin
                  state_nx  = IDLE;
                  rr_ptr_nx = cur + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         cur    <= '0;
         bcnt   <= '0;
         vld_d  <= 1'b0;
         sel_d  <= '0;
      end else begin
         state  <= state_nx;
         rr_ptr <= rr_ptr_nx;
         cur    <= cur_nx;
         bcnt   <= bcnt_nx;
         vld_d  <= |pop;
         sel_d  <= cur;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NPORT; i++) begin
         if (!reset) begin
            cnt[i] <= '0;
         end else if (pop[i] && (cnt[i] != {CNT_W{1'b1}})) begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   assign push    = vld_d ? onehot(dest) : '0;
   assign mux_sel = sel_d;
   assign idle    = (state == IDLE) && (&empty) && !vld_d;
   assign cnt_out = cnt[cnt_sel];

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: queue-based FIFO model, grant-level
// round-robin reference and a pop->push scoreboard.
module tb_arbitro_rr;

   localparam int BURST   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [3:0]       empty = 4'hF;
   logic [3:0]       afull;
   logic [1:0]       dest;
   logic [3:0]       pop;
   logic [3:0]       push;
   logic [1:0]       mux_sel;
   logic             idle;
   logic [1:0]       cnt_sel;
   logic [CNT_W-1:0] cnt_out;

   arbitro_rr #(.BURST(BURST), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .empty   (empty),
      .afull   (afull),
      .dest    (dest),
      .pop     (pop),
      .push    (push),
      .mux_sel (mux_sel),
      .idle    (idle),
      .cnt_sel (cnt_sel),
      .cnt_out (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sel;
      int dst;
      int cyc;
   } exp_t;

   exp_t sb [$];
   int   fifo [4][$];
   int   log_q [$];
   bit   log_en;
   int   checks;
   int   failures;
   int   cyc;
   int   npop;
   int   m_ptr;
   int   m_cur;
   int   m_used;
   bit   m_act;
   int   m_cnt [4];
   bit   had_pop;
   int   last_dest;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Input FIFO model drives empty/dest shortly after each clock edge.
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 4; i++) empty[i] = (fifo[i].size() == 0);
      dest = had_pop ? 2'(last_dest) : 2'($urandom_range(0, 3));
   end

   // Monitor: scoreboard pop, order model, counter model.
   always @(negedge clk) begin
      exp_t e;
      int   idx;
      bit   found;
      cyc++;
      if (log_en) log_q.push_back(int'(pop));
      if (!reset) begin
         chk("pop_in_reset", int'(pop), 0);
         chk("push_in_reset", int'(push), 0);
         sb.delete();
         m_act   = 1'b0;
         m_ptr   = 0;
         had_pop = 1'b0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         if (push != 4'h0) begin
            if (sb.size() == 0) begin
               chk("unexpected_push", int'(push), 0);
            end else begin
               e = sb.pop_front();
               chk("push_dest", int'(push), 1 << e.dst);
               chk("mux_sel", int'(mux_sel), e.sel);
               chk("push_latency", cyc - e.cyc, 1);
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("missing_push", int'(push), 1 << sb[0].dst);
            void'(sb.pop_front());
         end
         if (afull != 4'h0) chk("pop_under_afull", int'(pop), 0);
         had_pop = (pop != 4'h0);
         if (pop != 4'h0) begin
            chk("pop_onehot", $countones(pop), 1);
            idx = 0;
            for (int k = 3; k >= 0; k--) if (pop[k]) idx = k;
            if (!m_act) begin
               found = 1'b0;
               for (int k = 0; k < 4; k++) begin
                  if (!found && fifo[(m_ptr + k) % 4].size() != 0) begin
                     m_cur = (m_ptr + k) % 4;
                     found = 1'b1;
                  end
               end
               m_act  = 1'b1;
               m_used = 0;
            end
            chk("grant_order", idx, m_cur);
            if (fifo[idx].size() == 0) begin
               chk("pop_while_empty", int'(empty[idx]), 0);
            end else begin
               last_dest = fifo[idx].pop_front();
               sb.push_back('{sel: idx, dst: last_dest, cyc: cyc});
            end
            npop++;
            m_used++;
            if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
            if (m_used == BURST || fifo[m_cur].size() == 0) begin
               m_act = 1'b0;
               m_ptr = (m_cur + 1) % 4;
            end
         end
      end
   end

   function automatic bit busy();
      int n = 0;
      for (int i = 0; i < 4; i++) n += fifo[i].size();
      return (n != 0) || (sb.size() != 0);
   endfunction

   task automatic wait_drain();
      int n = 0;
      while ((busy() || !idle) && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("drain_in_time", int'(n < 2000), 1);
      chk("idle_after_drain", int'(idle), 1);
   endtask

   task automatic check_cnts();
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk($sformatf("cnt%0d", s), int'(cnt_out), m_cnt[s]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk("cnt_cleared", int'(cnt_out), 0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic load(input int port, input int n, input int d);
      for (int k = 0; k < n; k++) begin
         fifo[port].push_back(d < 0 ? int'($urandom_range(0, 3)) : d);
      end
   endtask

   initial begin
      int pat [7];
      int f;
      int base;
      int n;
      pat = '{2, 2, 2, 2, 0, 2, 2};
      reset   = 1'b0;
      afull   = 4'h0;
      cnt_sel = 2'd0;
      log_en  = 1'b0;

      // Reset with every input non-empty, then first grant.
      for (int i = 0; i < 4; i++) load(i, 1, -1);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #1 chk("rel_cycle1_pop", int'(pop), 0);
      @(negedge clk);
      #1 chk("first_pop", int'(pop), 1);
      wait_drain();

      // Fairness across four full inputs.
      do_reset();
      for (int i = 0; i < 4; i++) load(i, 8, -1);
      wait_drain();
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1 chk($sformatf("fair_cnt%0d", s), int'(cnt_out), 8);
      end

      // Burst limit on a single input.
      log_q.delete();
      log_en = 1'b1;
      @(posedge clk);
      #1 load(1, 6, 2);
      wait_drain();
      log_en = 1'b0;
      f = -1;
      for (int k = log_q.size() - 1; k >= 0; k--) if (log_q[k] != 0) f = k;
      chk("burst_seen", int'(f >= 0), 1);
      for (int k = 0; k < 7; k++) begin
         if (f >= 0 && f + k < log_q.size()) chk("burst_pat", log_q[f + k], pat[k]);
      end

      // Backpressure mid-burst.
      base = npop;
      @(posedge clk);
      #1;
      load(0, 6, 3);
      load(1, 2, 0);
      n = 0;
      while (npop < base + 2 && n < 200) begin
         @(negedge clk);
         #1 n++;
      end
      chk("bp_reach", int'(npop >= base + 2), 1);
      @(posedge clk);
      #1 afull = 4'b1000;
      @(negedge clk);
      #1;
      chk("bp_pop_drop", int'(pop), 0);
      chk("bp_trailing_push", int'(push), 4'b1000);
      @(negedge clk);
      #1 chk("bp_no_push", int'(push), 0);
      repeat (3) @(posedge clk);
      #1 afull = 4'h0;
      @(negedge clk);
      #1 chk("bp_resume", int'(pop), 1);
      wait_drain();

      // Reset while a word is in flight.
      @(posedge clk);
      #1 load(2, 3, 1);
      n = 0;
      while (pop == 4'h0 && n < 200) begin
         @(negedge clk);
         #1 n++;
      end
      chk("rmf_pop_seen", int'(pop), 4'b0100);
      reset = 1'b0;
      @(negedge clk);
      #1 chk("rmf_no_push", int'(push), 0);
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1 chk("rmf_cnt_zero", int'(cnt_out), 0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      wait_drain();
      check_cnts();

      // Counter saturation.
      do_reset();
      load(2, 20, -1);
      wait_drain();
      cnt_sel = 2'd2;
      #1 chk("cnt_sat", int'(cnt_out), 15);
      check_cnts();

      // Randomized loads with random backpressure.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) load(i, $urandom_range(0, 10), -1);
         n = 0;
         while (busy() && n < 3000) begin
            @(posedge clk);
            #1 afull = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            n++;
         end
         afull = 4'h0;
         wait_drain();
         check_cnts();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
